// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus-interface controller and the datapath stage
// downstream of it.
//   dp_state_t  : datapath FSM state (FILL, DRAIN, DONE)
//   BUS_DATA_W  : default data word width
//   BUS_DEPTH   : default buffer depth (power of two, >= 2)
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } dp_state_t;

  localparam int BUS_DATA_W = 8;
  localparam int BUS_DEPTH  = 8;

endpackage : bus_pkg

// File: rtl/bus_buffer_mem.sv
// -----------------------------------------------------------------------------
// bus_buffer_mem
// DEPTH x DATA_W register array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk      : rising-edge clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (combinational read)
//   rdata_o  : read data
// -----------------------------------------------------------------------------
module bus_buffer_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : bus_buffer_mem

// File: rtl/bus_datapath.sv
// -----------------------------------------------------------------------------
// bus_datapath
// Captures words into a DEPTH-entry buffer under control of the l/add strobes,
// then drains the full buffer onto a valid/ready output bus. Reports the
// address-limit flag (al) back to the controller while full or draining.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   clr        : synchronous clear, highest priority
//   l          : load din at the current write address
//   add        : advance write address / committed count
//   din        : data to capture
//   al         : address-limit flag (full, draining or done)
//   count      : committed words, 0..DEPTH
//   bus_data   : word presented on the output bus
//   bus_valid  : bus_data valid
//   bus_ready  : downstream accepts word
//   bus_par    : even parity of bus_data (only with BUS_DATAPATH_PARITY_EN)
// Optional feature macro: BUS_DATAPATH_PARITY_EN
// -----------------------------------------------------------------------------
module bus_datapath
  import bus_pkg::*;
#(
  parameter int DATA_W = BUS_DATA_W,
  parameter int DEPTH  = BUS_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      l,
  input  logic                      add,
  input  logic [DATA_W-1:0]         din,
  output logic                      al,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      bus_valid,
`ifdef BUS_DATAPATH_PARITY_EN
  output logic                      bus_par,
`endif
  input  logic                      bus_ready
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  dp_state_t         state_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              al_q;
  logic              bus_valid_q;
  logic [DATA_W-1:0] bus_data_q;
  logic [DATA_W-1:0] rd_data;
  logic              handshake;
  logic              mem_we;

  assign handshake = bus_valid_q & bus_ready;
  assign mem_we    = (state_q == FILL) & l & ~clr;

  // The read port looks at the address the next word will come from, so the
  // registered bus_data can be loaded with it on the same edge as the
  // handshake. In FILL rd_addr_q is 0, which is what entering DRAIN needs.
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (state_q == DRAIN && handshake) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end
  end

  bus_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr_q),
    .wdata_i (din),
    .raddr_i (rd_addr_d),
    .rdata_o (rd_data)
  );

`ifdef BUS_DATAPATH_PARITY_EN
  logic bus_par_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      count_q     <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      al_q        <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
`ifdef BUS_DATAPATH_PARITY_EN
      bus_par_q   <= 1'b0;
`endif
    end else if (clr) begin
      // A handshake in this cycle still completes on the bus; only the
      // internal state is discarded.
      state_q     <= FILL;
      count_q     <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      al_q        <= 1'b0;
      bus_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (add) begin
            wr_addr_q <= wr_addr_q + 1'b1;
            count_q   <= count_q + 1'b1;
            if (count_q == LAST_COUNT) begin
              state_q     <= DRAIN;
              al_q        <= 1'b1;
              bus_valid_q <= 1'b1;
              rd_addr_q   <= '0;
              bus_data_q  <= rd_data;
`ifdef BUS_DATAPATH_PARITY_EN
              bus_par_q   <= ^rd_data;
`endif
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            rd_addr_q <= rd_addr_d;
            count_q   <= count_q - 1'b1;
            if (rd_addr_q == LAST_ADDR) begin
              state_q     <= DONE;
              bus_valid_q <= 1'b0;
              count_q     <= '0;
            end else begin
              bus_data_q <= rd_data;
`ifdef BUS_DATAPATH_PARITY_EN
              bus_par_q  <= ^rd_data;
`endif
            end
          end
        end
        DONE: begin
          // Wait for clr.
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign al        = al_q;
  assign count     = count_q;
  assign bus_data  = bus_data_q;
  assign bus_valid = bus_valid_q;
`ifdef BUS_DATAPATH_PARITY_EN
  assign bus_par   = bus_par_q;
`endif

endmodule : bus_datapath

// File: doc/bus_datapath.md
Name: bus_datapath

Overview:
- Datapath stage directly downstream of the bus-interface controller; consumes its clr, l and add strobes and returns the al (address-limit) flag.
- Captures input words into a DEPTH-entry buffer at an internal write address.
- Once the buffer is full, drains it word by word onto an output bus using a valid/ready handshake.

Parameters:
- DATA_W, 8, width of input and bus data words.
- DEPTH, 8, buffer entries; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear from controller.
- l  input  1  load strobe: write din at current write address.
- add  input  1  advance write address.
- din  input  DATA_W  data to capture.
- al  output  1  address-limit flag to controller; buffer full or draining.
- count  output  ADDR_W+1  number of committed words, 0..DEPTH.
- bus_data  output  DATA_W  word presented on bus.
- bus_valid  output  1  bus_data valid.
- bus_ready  input  1  downstream accepts word.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous) forces:
  - state=FILL, count=0, wr_addr=0, rd_addr=0;
  - al=0, bus_valid=0, bus_data=0.
  - Buffer contents are not reset.
- Reset mid-drain aborts immediately: bus_valid drops without waiting for a clock.
- FSM states: FILL, DRAIN, DONE.
- FILL:
  - l=1 writes din to mem[wr_addr] at the edge.
  - add=1 increments wr_addr and count.
  - l and add in the same cycle: write at the current wr_addr, then advance.
  - add that makes count==DEPTH moves the FSM to DRAIN at that edge.
  - wr_addr wraps to 0 naturally.
- Entering DRAIN, at the same edge:
  - al=1, bus_valid=1, bus_data=mem[0], rd_addr=0.
  - al therefore asserts one cycle after the final add.
- DRAIN:
  - bus_data and bus_valid are held stable while bus_ready=0.
  - A handshake (bus_valid & bus_ready) advances rd_addr, decrements count and loads the next word the following cycle. Back-to-back transfers are allowed, one word per cycle.
  - The handshake on word DEPTH-1 moves the FSM to DONE: bus_valid=0, count=0, al stays 1.
- DONE: holds until clr.
- l and add are ignored in DRAIN and DONE.
- clr (any state): next edge returns to FILL with count=0, addresses 0, al=0, bus_valid=0.
  - clr has priority over l, add and a same-cycle handshake; a word handshaked in that cycle counts as transferred by the bus, but the state is still cleared.
- l without add in FILL overwrites the same entry and does not change count.

Optional Feature:
- Macro: BUS_DATAPATH_PARITY_EN.
- When defined:
  - Extra output port bus_par (1 bit), registered alongside bus_data and equal to the even parity (XOR reduction) of bus_data.
  - bus_par resets to 0.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bus_pkg holds:
  - typedef enum logic [1:0] dp_state_t {FILL, DRAIN, DONE};
  - default constants BUS_DATA_W=8 and BUS_DEPTH=8, also used by the controller's bench.
- One natural sub-module, bus_buffer_mem:
  - DEPTH x DATA_W register array with one write port and one asynchronous read port;
  - no reset on contents.

Test Plan:
1. Reset values (DEPTH=4, DATA_W=8): assert rst_n=0 mid-drain -> bus_valid, al, count drop to 0 without a clock edge; after release, state FILL.
2. Fill: clr, then four cycles of l=1 add=1 with din=8'h11,8'h22,8'h33,8'h44 -> count 1,2,3,4; al=1 the cycle after the 4th add; bus_valid=1 with bus_data=8'h11.
3. Backpressure: hold bus_ready=0 for 3 cycles, then 1 for 4 cycles -> bus_data holds 8'h11, then 8'h11,22,33,44 accepted on consecutive cycles; then bus_valid=0, DONE, al=1 until clr.
4. Load without advance: l=1 din=8'hAA, then l=1 din=8'hBB, then add=1 -> count=1 and mem[0]=8'hBB (visible as first drained word).
5. Clear priority: in DRAIN after 2 handshakes, assert clr with bus_ready=1 -> next cycle state FILL, count=0, al=0, bus_valid=0; l/add pulses issued during DONE earlier have no effect.
6. BUS_DATAPATH_PARITY_EN defined: drain words 8'h03 and 8'h07 -> bus_par=0 then 1.
